rns_mac_pipe: RTL and testbench

Parametrised, pipelined residue-number-system multiply-accumulate unit: the streaming successor to the combinational per-channel RNS add/mul blocks. Each accepted beat carries one operand pair of NUM_CH residues. Per channel it forms (a*b) mod m_i and adds it modulo m_i into an accumulator. On the beat flagged last it emits the packet's accumulated residue vector and beat count over a valid/ready output. It sits between the int-to-RNS converter and the RNS-to-int converter in the filter datapath, as the FIR tap engine.

---
 rtl/rns_pkg.sv | 23 ++
 rtl/rns_ch_mac.sv | 60 ++++++
 rtl/rns_mac_pipe.sv | 81 ++++++++
 tb/tb_rns_mac_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared constants, residue word type and modulus lookup for the RNS datapath.
package rns_pkg;

  localparam int MAX_MODULI_W = 256;
  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CH_W     = 8;
  localparam logic [DEF_NUM_CH*DEF_CH_W-1:0] DEF_MODULI = {8'd233, 8'd239, 8'd241, 8'd251};

  typedef logic [DEF_CH_W-1:0] residue_t;

  // Extracts channel i's modulus from a packed vector of ch_w-bit fields.
  function automatic logic [31:0] mod_of(input logic [MAX_MODULI_W-1:0] moduli,
                                         input int i,
                                         input int ch_w);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < ch_w) m[b] = moduli[i*ch_w + b];
    end
    return m;
  endfunction

endpackage

// File: rtl/rns_ch_mac.sv
// One residue channel: registered modular multiply, then a modular accumulate
// that hands the packet total to its own output register on the last beat.
module rns_ch_mac
  import rns_pkg::*;
#(
  parameter int          CH_W = DEF_CH_W,
  parameter logic [31:0] MOD  = 32'd251
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_fire,
  input  logic [CH_W-1:0] in_a,
  input  logic [CH_W-1:0] in_b,
  input  logic            s2_fire,
  input  logic            s2_last,
  output logic [CH_W-1:0] out_acc
);

  localparam logic [2*CH_W-1:0] MOD_P = (2*CH_W)'(MOD);
  localparam logic [CH_W:0]     MOD_S = (CH_W+1)'(MOD);

  logic [2*CH_W-1:0] prod;
  logic [CH_W-1:0]   p;
  logic [CH_W-1:0]   acc;
  logic [CH_W-1:0]   acc_next;
  logic [CH_W:0]     sum;

  // Full-width product so operands at or above the modulus still reduce correctly.
  assign prod = (2*CH_W)'(in_a) * (2*CH_W)'(in_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else if (in_fire) begin
      p <= CH_W'(prod % MOD_P);
    end
  end

  always_comb begin
    sum = {1'b0, acc} + {1'b0, p};
    if (sum >= MOD_S) sum = sum - MOD_S;
    acc_next = CH_W'(sum);
  end

  // The last beat clears the accumulator so the next packet starts without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      out_acc <= '0;
    end else if (s2_fire) begin
      if (s2_last) begin
        out_acc <= acc_next;
        acc     <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

endmodule

// File: rtl/rns_mac_pipe.sv
// Pipelined RNS multiply-accumulate: per-channel lanes plus shared handshake,
// last-flag pipeline and saturating beat counter.
module rns_mac_pipe
  import rns_pkg::*;
#(
  parameter int                     NUM_CH = DEF_NUM_CH,
  parameter int                     CH_W   = DEF_CH_W,
  parameter logic [NUM_CH*CH_W-1:0] MODULI = DEF_MODULI,
  parameter int                     CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_CH*CH_W-1:0] in_a,
  input  logic [NUM_CH*CH_W-1:0] in_b,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CH*CH_W-1:0] out_acc,
  output logic [CNT_W-1:0]       out_count
);

  logic             en;
  logic             in_fire;
  logic             s2_fire;
  logic             s1_valid;
  logic             s1_last;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;

  // The whole pipe freezes only while a finished result is waiting downstream.
  assign en        = !(out_valid && !out_ready);
  assign in_ready  = en;
  assign in_fire   = in_valid && en;
  assign s2_fire   = s1_valid && en;
  assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rns_ch_mac #(
      .CH_W (CH_W),
      .MOD  (mod_of(MAX_MODULI_W'(MODULI), i, CH_W))
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .in_fire (in_fire),
      .in_a    (in_a[i*CH_W +: CH_W]),
      .in_b    (in_b[i*CH_W +: CH_W]),
      .s2_fire (s2_fire),
      .s2_last (s1_last),
      .out_acc (out_acc[i*CH_W +: CH_W])
    );
  end

  // A result loading in the same cycle it is consumed keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      count     <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      if (en) begin
        s1_valid <= in_valid;
        s1_last  <= in_last;
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (s2_fire) begin
        if (s1_last) begin
          out_count <= count_inc;
          out_valid <= 1'b1;
          count     <= '0;
        end else begin
          count <= count_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_rns_mac_pipe.sv
// Scoreboard bench for rns_mac_pipe: a residue model queues expected results
// at input acceptance, a monitor pops and compares them at output handshake.
module tb_rns_mac_pipe;
  import rns_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int CH_W    = 8;
  localparam int CNT_W   = 8;
  localparam int ACC_W   = NUM_CH*CH_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
  } result_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] in_a;
  logic [ACC_W-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;

  int unsigned chMod [NUM_CH] = '{251, 241, 239, 233};
  int unsigned modelAcc [NUM_CH];
  int unsigned modelCount;
  result_t     expQ [$];
  int          checks = 0;
  int          failures = 0;
  logic        holdReady = 1'b0;
  logic        monitorOn = 1'b0;
  int          b2bRun;

  always #5 clk = ~clk;

  rns_mac_pipe #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .MODULI (DEF_MODULI),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [ACC_W-1:0] rep(input logic [CH_W-1:0] v);
    return {NUM_CH{v}};
  endfunction

  task automatic clearModel();
    for (int c = 0; c < NUM_CH; c++) modelAcc[c] = 0;
    modelCount = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Called at negedge+1; returns at negedge+1 after the accepting edge with in_valid still high.
  task automatic applyStimulus(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b, input logic last);
    int      waitCycles;
    result_t r;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    waitCycles = 0;
    while (in_ready !== 1'b1 && waitCycles < 200) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    if (in_ready !== 1'b1) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    for (int c = 0; c < NUM_CH; c++) begin
      int unsigned pa;
      int unsigned pb;
      pa = a[c*CH_W +: CH_W];
      pb = b[c*CH_W +: CH_W];
      modelAcc[c] = (modelAcc[c] + (pa * pb) % chMod[c]) % chMod[c];
    end
    if (modelCount < CNT_MAX) modelCount++;
    if (last) begin
      for (int c = 0; c < NUM_CH; c++) r.acc[c*CH_W +: CH_W] = CH_W'(modelAcc[c]);
      r.count = CNT_W'(modelCount);
      expQ.push_back(r);
      clearModel();
    end
    @(negedge clk);
    #1;
  endtask

  // Output side: drives out_ready, checks stall behaviour and scoreboard order.
  initial begin
    logic             heldPrev;
    logic [ACC_W-1:0] heldAcc;
    logic [CNT_W-1:0] heldCount;
    result_t          exp;
    heldPrev  = 1'b0;
    heldAcc   = '0;
    heldCount = '0;
    out_ready = 1'b1;
    wait (monitorOn);
    forever begin
      @(negedge clk);
      out_ready = !holdReady;
      #1;
      if (out_valid === 1'b1) begin
        if (!out_ready) checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        if (heldPrev) begin
          checkOutput("hold_acc", 64'(out_acc), 64'(heldAcc));
          checkOutput("hold_count", 64'(out_count), 64'(heldCount));
        end
        if (out_ready) begin
          heldPrev = 1'b0;
          if (expQ.size() == 0) begin
            checkOutput("unexpected_out", 64'd1, 64'd0);
          end else begin
            exp = expQ.pop_front();
            checkOutput("out_acc", 64'(out_acc), 64'(exp.acc));
            checkOutput("out_count", 64'(out_count), 64'(exp.count));
          end
        end else begin
          heldPrev  = 1'b1;
          heldAcc   = out_acc;
          heldCount = out_count;
        end
      end else begin
        heldPrev = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
    clearModel();
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_acc", 64'(out_acc), 64'd0);
    checkOutput("rst_out_count", 64'(out_count), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    monitorOn = 1'b1;
    idle(2);

    $display("[TB] single beat latency");
    applyStimulus(rep(8'd10), rep(8'd30), 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("lat_t1", 64'(out_valid), 64'd0);
    @(negedge clk);
    #2;
    checkOutput("lat_t2", 64'(out_valid), 64'd1);
    @(negedge clk);
    #2;
    checkOutput("lat_t3", 64'(out_valid), 64'd0);
    idle(3);

    $display("[TB] three-beat packet then accumulator clear");
    for (int k = 0; k < 3; k++) applyStimulus(rep(8'd250), rep(8'd250), k == 2);
    applyStimulus(rep(8'd1), rep(8'd5), 1'b1);
    idle(4);

    $display("[TB] output backpressure");
    holdReady = 1'b1;
    fork
      begin
        applyStimulus(rep(8'd3), rep(8'd4), 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus(rep(8'(k + 1)), rep(8'(k + 7)), k == 3);
        idle(1);
      end
      begin
        repeat (8) begin
          @(negedge clk);
          #1;
        end
        holdReady = 1'b0;
      end
    join
    idle(6);

    $display("[TB] back-to-back single-beat packets");
    b2bRun = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) applyStimulus(rep(8'(k*37 + 5)), rep(8'(k*11 + 200)), 1'b1);
        idle(1);
      end
      begin
        int w;
        w = 0;
        while (out_valid !== 1'b1 && w < 20) begin
          @(negedge clk);
          #2;
          w++;
        end
        while (out_valid === 1'b1 && b2bRun < 50) begin
          b2bRun++;
          @(negedge clk);
          #2;
        end
      end
    join
    checkOutput("b2b_run", 64'(b2bRun), 64'd6);
    idle(4);

    $display("[TB] 300-beat packet, counter saturation");
    for (int k = 0; k < 300; k++) applyStimulus(rep(8'd1), rep(8'd1), k == 299);
    idle(4);

    $display("[TB] reset mid-packet");
    applyStimulus(rep(8'd7), rep(8'd9), 1'b0);
    applyStimulus(rep(8'd7), rep(8'd9), 1'b0);
    idle(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    clearModel();
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_out_acc", 64'(out_acc), 64'd0);
    checkOutput("mid_rst_out_count", 64'(out_count), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(rep(8'd2), rep(8'd3), 1'b1);
    idle(4);

    guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checkOutput("drain", 64'(expQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
